// File: rtl/biriscv_trap_sequencer_pkg.sv
// rtl/biriscv_trap_sequencer_pkg.sv - exception codes, FSM states and trap record shared by the trap sequencer
package biriscv_trap_sequencer_pkg;

    localparam int EXCEPTION_W = 6;

    localparam logic [5:0] EXCEPTION_W_NONE             = 6'h00;
    localparam logic [5:0] EXCEPTION_MISALIGNED_FETCH   = 6'h10;
    localparam logic [5:0] EXCEPTION_FAULT_FETCH        = 6'h11;
    localparam logic [5:0] EXCEPTION_ILLEGAL_INSTRUCTION = 6'h12;
    localparam logic [5:0] EXCEPTION_BREAKPOINT         = 6'h13;
    localparam logic [5:0] EXCEPTION_MISALIGNED_LOAD    = 6'h14;
    localparam logic [5:0] EXCEPTION_FAULT_LOAD         = 6'h15;
    localparam logic [5:0] EXCEPTION_MISALIGNED_STORE   = 6'h16;
    localparam logic [5:0] EXCEPTION_FAULT_STORE        = 6'h17;
    localparam logic [5:0] EXCEPTION_ECALL_U            = 6'h18;
    localparam logic [5:0] EXCEPTION_ECALL_S            = 6'h19;
    localparam logic [5:0] EXCEPTION_ECALL_H            = 6'h1a;
    localparam logic [5:0] EXCEPTION_ECALL_M            = 6'h1b;
    localparam logic [5:0] EXCEPTION_PAGE_FAULT_INST    = 6'h1c;
    localparam logic [5:0] EXCEPTION_PAGE_FAULT_LOAD    = 6'h1d;
    localparam logic [5:0] EXCEPTION_PAGE_FAULT_STORE   = 6'h1f;
    localparam logic [5:0] EXCEPTION_INTERRUPT          = 6'h20;
    localparam logic [5:0] EXCEPTION_ERET_U             = 6'h30;
    localparam logic [5:0] EXCEPTION_ERET_S             = 6'h31;
    localparam logic [5:0] EXCEPTION_ERET_H             = 6'h32;
    localparam logic [5:0] EXCEPTION_ERET_M             = 6'h33;
    localparam logic [5:0] EXCEPTION_TYPE_MASK          = 6'h30;

    localparam logic [1:0] TS_IDLE  = 2'd0;
    localparam logic [1:0] TS_TRAP  = 2'd1;
    localparam logic [1:0] TS_FLUSH = 2'd2;

    typedef struct packed {
        logic [5:0]  exc;
        logic [31:0] pc;
        logic [31:0] addr;
    } trap_req_t;

endpackage

// File: rtl/biriscv_trap_sequencer_if.sv
// rtl/biriscv_trap_sequencer_if.sv - pipe, interrupt and regfile signals of the trap sequencer
interface biriscv_trap_sequencer_if;
    logic        p0_exc_valid_i;
    logic [5:0]  p0_exc_i;
    logic [31:0] p0_pc_i;
    logic [31:0] p0_addr_i;
    logic        p1_exc_valid_i;
    logic [5:0]  p1_exc_i;
    logic [31:0] p1_pc_i;
    logic [31:0] p1_addr_i;
    logic [31:0] irq_i;
    logic [31:0] irq_pc_i;
    logic        p0_csr_valid_i;
    logic [11:0] p0_csr_addr_i;
    logic [31:0] p0_csr_data_i;
    logic        p0_csr_ready_o;
    logic        p1_csr_valid_i;
    logic [11:0] p1_csr_addr_i;
    logic [31:0] p1_csr_data_i;
    logic        p1_csr_ready_o;
    logic [5:0]  exception_o;
    logic [31:0] exception_pc_o;
    logic [31:0] exception_addr_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        csr_branch_i;
    logic [31:0] csr_target_i;
    logic        branch_o;
    logic [31:0] branch_pc_o;
    logic        flush_o;
    logic        stall_o;

    modport master (
        output p0_exc_valid_i, p0_exc_i, p0_pc_i, p0_addr_i,
        output p1_exc_valid_i, p1_exc_i, p1_pc_i, p1_addr_i,
        output irq_i, irq_pc_i,
        output p0_csr_valid_i, p0_csr_addr_i, p0_csr_data_i,
        output p1_csr_valid_i, p1_csr_addr_i, p1_csr_data_i,
        output csr_branch_i, csr_target_i,
        input  p0_csr_ready_o, p1_csr_ready_o,
        input  exception_o, exception_pc_o, exception_addr_o,
        input  csr_waddr_o, csr_wdata_o,
        input  branch_o, branch_pc_o, flush_o, stall_o
    );

    modport slave (
        input  p0_exc_valid_i, p0_exc_i, p0_pc_i, p0_addr_i,
        input  p1_exc_valid_i, p1_exc_i, p1_pc_i, p1_addr_i,
        input  irq_i, irq_pc_i,
        input  p0_csr_valid_i, p0_csr_addr_i, p0_csr_data_i,
        input  p1_csr_valid_i, p1_csr_addr_i, p1_csr_data_i,
        input  csr_branch_i, csr_target_i,
        output p0_csr_ready_o, p1_csr_ready_o,
        output exception_o, exception_pc_o, exception_addr_o,
        output csr_waddr_o, csr_wdata_o,
        output branch_o, branch_pc_o, flush_o, stall_o
    );
endinterface

// File: rtl/biriscv_trap_sequencer_csr_wr_arb.sv
// rtl/biriscv_trap_sequencer_csr_wr_arb.sv - 2:1 fixed-priority CSR write grant and mux onto one write port
module biriscv_csr_wr_arb (
    input  logic        en,
    input  logic        p0_valid,
    input  logic [11:0] p0_addr,
    input  logic [31:0] p0_data,
    output logic        p0_ready,
    input  logic        p1_valid,
    input  logic [11:0] p1_addr,
    input  logic [31:0] p1_data,
    output logic        p1_ready,
    output logic [11:0] waddr,
    output logic [31:0] wdata
);
    always_comb begin
        p0_ready = en & p0_valid;
        p1_ready = en & p1_valid & ~p0_valid;
        waddr    = 12'h000;
        wdata    = 32'h0;
        if (p0_ready) begin
            waddr = p0_addr;
            wdata = p0_data;
        end else if (p1_ready) begin
            waddr = p1_addr;
            wdata = p1_data;
        end
    end
endmodule

// File: rtl/biriscv_trap_sequencer.sv
// rtl/biriscv_trap_sequencer.sv - arbitrates pipe traps/interrupts into single-cycle regfile exceptions and serialises CSR writes
module biriscv_trap_sequencer
    import biriscv_trap_sequencer_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input logic                      clk_i,
    input logic                      rst_i,
    biriscv_trap_sequencer_if.slave  bus
);
    logic [1:0]  state_q;
    logic [3:0]  cnt_q;
    trap_req_t   trap_q;
    trap_req_t   trap_sel;
    logic        branch_q;
    logic [31:0] branch_pc_q;
    logic        idle;
    logic        trap_req;
    logic        csr_en;

    assign idle     = (state_q == TS_IDLE);
    assign trap_req = bus.p0_exc_valid_i | bus.p1_exc_valid_i | (|bus.irq_i);

    // pipe0 is the older instruction, so its request masks both pipe1 and interrupts
    always_comb begin
        trap_sel = '{exc: bus.p0_exc_i, pc: bus.p0_pc_i, addr: bus.p0_addr_i};
        if (!bus.p0_exc_valid_i && bus.p1_exc_valid_i)
            trap_sel = '{exc: bus.p1_exc_i, pc: bus.p1_pc_i, addr: bus.p1_addr_i};
        else if (!bus.p0_exc_valid_i && !bus.p1_exc_valid_i)
            trap_sel = '{exc: EXCEPTION_INTERRUPT, pc: bus.irq_pc_i, addr: 32'h0};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= TS_IDLE;
            cnt_q       <= 4'd0;
            trap_q      <= '0;
            branch_q    <= 1'b0;
            branch_pc_q <= 32'h0;
        end else begin
            case (state_q)
                TS_IDLE: begin
                    branch_q <= 1'b0;
                    if (trap_req) begin
                        trap_q  <= trap_sel;
                        state_q <= TS_TRAP;
                    end
                end
                TS_TRAP: begin
                    branch_q    <= bus.csr_branch_i;
                    branch_pc_q <= bus.csr_target_i;
                    cnt_q       <= 4'(FLUSH_CYCLES - 1);
                    state_q     <= TS_FLUSH;
                end
                TS_FLUSH: begin
                    branch_q    <= 1'b0;
                    branch_pc_q <= 32'h0;
                    if (cnt_q == 4'd0)
                        state_q <= TS_IDLE;
                    else
                        cnt_q <= cnt_q - 4'd1;
                end
                default: state_q <= TS_IDLE;
            endcase
        end
    end

    assign bus.exception_o      = (state_q == TS_TRAP) ? trap_q.exc  : 6'h00;
    assign bus.exception_pc_o   = (state_q == TS_TRAP) ? trap_q.pc   : 32'h0;
    assign bus.exception_addr_o = (state_q == TS_TRAP) ? trap_q.addr : 32'h0;
    assign bus.branch_o         = branch_q;
    assign bus.branch_pc_o      = branch_pc_q;
    assign bus.flush_o          = ~idle;
    assign bus.stall_o          = ~idle;

    // any pending trap or interrupt blocks CSR writes so a write never races the trap it belongs with
    assign csr_en = idle & ~rst_i & ~trap_req;

    biriscv_csr_wr_arb u_csr_wr_arb (
        .en       (csr_en),
        .p0_valid (bus.p0_csr_valid_i),
        .p0_addr  (bus.p0_csr_addr_i),
        .p0_data  (bus.p0_csr_data_i),
        .p0_ready (bus.p0_csr_ready_o),
        .p1_valid (bus.p1_csr_valid_i),
        .p1_addr  (bus.p1_csr_addr_i),
        .p1_data  (bus.p1_csr_data_i),
        .p1_ready (bus.p1_csr_ready_o),
        .waddr    (bus.csr_waddr_o),
        .wdata    (bus.csr_wdata_o)
    );
endmodule
